// File: rtl/phase_ramp_gen_pkg.sv
// Shared definitions for the phase ramp generator: FSM encoding and
// saturation limits of a signed accumulator of a given width.
package phase_ramp_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SCALE    = 2'd1,
    ST_ACCUM    = 2'd2,
    ST_STEP_OUT = 2'd3
  } state_e;

  // Limits are returned in 64 bits; callers keep the low w bits.
  function automatic logic signed [63:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/sat_add.sv
// Signed W-bit adder that clamps to the representable range and flags
// when the clamp was applied.
module sat_add
  import phase_ramp_gen_pkg::*;
#(
  parameter int W = 32
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic signed [W-1:0] o_sum,
  output logic                o_ovf
);

  localparam logic signed [63:0] MAX64 = sat_max(W);
  localparam logic signed [63:0] MIN64 = sat_min(W);
  localparam logic signed [W-1:0] MAX_V = MAX64[W-1:0];
  localparam logic signed [W-1:0] MIN_V = MIN64[W-1:0];

  logic signed [W-1:0] raw_sum;

  always_comb begin
    raw_sum = i_a + i_b;
    // Overflow only when both operands share a sign the result lost.
    o_ovf   = (i_a[W-1] == i_b[W-1]) && (raw_sum[W-1] != i_a[W-1]);
    o_sum   = raw_sum;
    if (o_ovf) begin
      o_sum = i_a[W-1] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/phase_ramp_gen.sv
// Phase ramp generator: integrates scaled error into a phase step and
// accumulates that step into a wrapping ramp that drives the DAC.
module phase_ramp_gen
  import phase_ramp_gen_pkg::*;
#(
  parameter int DAC_BIT = 16,
  parameter int ACC_BIT = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_status,
  input  logic                      i_fb_on,
  input  logic signed [ACC_BIT-1:0] i_err,
  input  logic                      i_step_sync,
  input  logic                      i_ramp_sync,
  input  logic                      i_polarity,
  input  logic        [4:0]         i_gain1_sel,
  input  logic        [4:0]         i_gain2_sel,
  input  logic signed [ACC_BIT-1:0] i_const_step,
  input  logic signed [DAC_BIT-1:0] i_mod_h,
  input  logic signed [DAC_BIT-1:0] i_mod_l,
  output logic signed [ACC_BIT-1:0] o_step,
  output logic        [ACC_BIT-1:0] o_ramp,
  output logic        [DAC_BIT-1:0] o_dac,
  output logic                      o_sat,
  output logic                      o_sync_miss
);

  state_e                    state_q, state_d;
  logic signed [ACC_BIT-1:0] e1_q, e1_d;
  logic signed [ACC_BIT-1:0] acc_q, acc_d;
  logic signed [ACC_BIT-1:0] step_q, step_d;
  logic        [ACC_BIT-1:0] ramp_q, ramp_d;
  logic        [DAC_BIT-1:0] dac_q, dac_d;
  logic                      sat_q, sat_d;
  logic                      miss_q, miss_d;
  logic signed [ACC_BIT-1:0] acc_sum;
  logic                      acc_ovf;

  sat_add #(.W(ACC_BIT)) u_sat_add (
    .i_a   (acc_q),
    .i_b   (e1_q),
    .o_sum (acc_sum),
    .o_ovf (acc_ovf)
  );

  // Each state's register is loaded on the edge that enters that state,
  // so a step_sync at cycle t shows the new o_step during cycle t+3.
  always_comb begin
    state_d = state_q;
    e1_d    = e1_q;
    acc_d   = acc_q;
    step_d  = step_q;
    ramp_d  = ramp_q;
    sat_d   = sat_q;
    miss_d  = miss_q;
    dac_d   = ramp_q[ACC_BIT-1 -: DAC_BIT] + (i_polarity ? i_mod_h : i_mod_l);

    if (i_ramp_sync) begin
      ramp_d = ramp_q + step_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_step_sync) begin
          state_d = ST_SCALE;
          e1_d    = i_err >>> i_gain1_sel;
        end
      end
      ST_SCALE: begin
        state_d = ST_ACCUM;
        acc_d   = acc_sum;
        if (acc_ovf) begin
          sat_d = 1'b1;
        end
      end
      ST_ACCUM: begin
        state_d = ST_STEP_OUT;
        step_d  = i_fb_on ? (acc_q >>> i_gain2_sel) : i_const_step;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (i_step_sync && (state_q != ST_IDLE)) begin
      miss_d = 1'b1;
    end

    // Dropping the loop enable aborts any sequence before o_step updates.
    if (!i_status) begin
      state_d = ST_IDLE;
      e1_d    = '0;
      acc_d   = '0;
      step_d  = '0;
      ramp_d  = '0;
      dac_d   = '0;
      sat_d   = 1'b0;
      miss_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      e1_q    <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      ramp_q  <= '0;
      dac_q   <= '0;
      sat_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      e1_q    <= e1_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      ramp_q  <= ramp_d;
      dac_q   <= dac_d;
      sat_q   <= sat_d;
      miss_q  <= miss_d;
    end
  end

  assign o_step      = step_q;
  assign o_ramp      = ramp_q;
  assign o_dac       = dac_q;
  assign o_sat       = sat_q;
  assign o_sync_miss = miss_q;

endmodule

// File: tb/tb_phase_ramp_gen.sv
// Directed and randomized checks of phase_ramp_gen against a cycle-level
// arithmetic reference model.
module tb_phase_ramp_gen;

  localparam int DW = 16;
  localparam int AW = 32;
  localparam longint ACC_MAX = 64'sd2147483647;
  localparam longint ACC_MIN = -64'sd2147483648;

  logic                 i_clk = 1'b0;
  logic                 i_rst_n;
  logic                 i_status;
  logic                 i_fb_on;
  logic signed [AW-1:0] i_err;
  logic                 i_step_sync;
  logic                 i_ramp_sync;
  logic                 i_polarity;
  logic        [4:0]    i_gain1_sel;
  logic        [4:0]    i_gain2_sel;
  logic signed [AW-1:0] i_const_step;
  logic signed [DW-1:0] i_mod_h;
  logic signed [DW-1:0] i_mod_l;
  logic signed [AW-1:0] o_step;
  logic        [AW-1:0] o_ramp;
  logic        [DW-1:0] o_dac;
  logic                 o_sat;
  logic                 o_sync_miss;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: busy = cycles since an accepted step_sync (0 = idle).
  int     m_busy, n_busy;
  longint m_e1, m_acc, m_step, m_ramp, m_dac, m_sat, m_miss;
  longint n_e1, n_acc, n_step, n_ramp, n_dac, n_sat, n_miss;

  phase_ramp_gen #(.DAC_BIT(DW), .ACC_BIT(AW)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_status     (i_status),
    .i_fb_on      (i_fb_on),
    .i_err        (i_err),
    .i_step_sync  (i_step_sync),
    .i_ramp_sync  (i_ramp_sync),
    .i_polarity   (i_polarity),
    .i_gain1_sel  (i_gain1_sel),
    .i_gain2_sel  (i_gain2_sel),
    .i_const_step (i_const_step),
    .i_mod_h      (i_mod_h),
    .i_mod_l      (i_mod_l),
    .o_step       (o_step),
    .o_ramp       (o_ramp),
    .o_dac        (o_dac),
    .o_sat        (o_sat),
    .o_sync_miss  (o_sync_miss)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    longint s;
    longint modv;
    n_busy = m_busy; n_e1 = m_e1; n_acc = m_acc; n_step = m_step;
    n_ramp = m_ramp; n_sat = m_sat; n_miss = m_miss;
    modv  = i_polarity ? longint'(i_mod_h) : longint'(i_mod_l);
    n_dac = ((m_ramp >> 16) + modv) & 64'hFFFF;
    if (i_ramp_sync) n_ramp = (m_ramp + m_step) & 64'hFFFF_FFFF;
    if (i_step_sync && m_busy != 0) n_miss = 1;
    if (m_busy == 0) begin
      if (i_step_sync) begin
        n_busy = 1;
        n_e1   = longint'(i_err) >>> i_gain1_sel;
      end
    end else if (m_busy == 1) begin
      n_busy = 2;
      s = m_acc + m_e1;
      if (s > ACC_MAX) begin s = ACC_MAX; n_sat = 1; end
      else if (s < ACC_MIN) begin s = ACC_MIN; n_sat = 1; end
      n_acc = s;
    end else if (m_busy == 2) begin
      n_busy = 3;
      n_step = i_fb_on ? (m_acc >>> i_gain2_sel) : longint'(i_const_step);
    end else begin
      n_busy = 0;
    end
    if (!i_status) begin
      n_busy = 0; n_e1 = 0; n_acc = 0; n_step = 0;
      n_ramp = 0; n_dac = 0; n_sat = 0; n_miss = 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge i_clk);
    #1;
    m_busy = n_busy; m_e1 = n_e1; m_acc = n_acc; m_step = n_step;
    m_ramp = n_ramp; m_dac = n_dac; m_sat = n_sat; m_miss = n_miss;
    check("step", o_step, m_step);
    check("ramp", o_ramp, m_ramp);
    check("dac",  o_dac,  m_dac);
    check("sat",  o_sat,  m_sat);
    check("miss", o_sync_miss, m_miss);
  endtask

  // Returns in cycle t+3 of a step_sync issued at cycle t.
  task automatic step_pulse();
    i_step_sync = 1'b1;
    tick();
    i_step_sync = 1'b0;
    tick();
    tick();
  endtask

  task automatic clear_loop();
    i_status = 1'b0;
    tick();
    i_status = 1'b1;
  endtask

  task automatic ramp_pulse();
    i_ramp_sync = 1'b1;
    tick();
    i_ramp_sync = 1'b0;
  endtask

  initial begin
    i_rst_n = 1'b0; i_status = 1'b0; i_fb_on = 1'b1; i_err = '0;
    i_step_sync = 1'b0; i_ramp_sync = 1'b0; i_polarity = 1'b0;
    i_gain1_sel = '0; i_gain2_sel = '0; i_const_step = '0;
    i_mod_h = '0; i_mod_l = '0;
    m_busy = 0; m_e1 = 0; m_acc = 0; m_step = 0; m_ramp = 0;
    m_dac = 0; m_sat = 0; m_miss = 0;

    repeat (2) @(posedge i_clk);
    #1;
    check("rst_step", o_step, 0);
    check("rst_ramp", o_ramp, 0);
    check("rst_dac",  o_dac,  0);
    check("rst_sat",  o_sat,  0);
    check("rst_miss", o_sync_miss, 0);
    i_rst_n = 1'b1;
    i_status = 1'b1;

    // Closed loop, first pulse after reset
    i_gain1_sel = 5'd2; i_gain2_sel = 5'd0; i_err = 32'sd100;
    step_pulse();
    check("cl_step_25", o_step, 25);
    tick();
    step_pulse();
    check("cl_step_50", o_step, 50);
    tick();

    // Saturation and recovery
    clear_loop();
    i_gain1_sel = 5'd0; i_err = 32'sh7FFF_FFF0;
    step_pulse(); tick();
    i_err = 32'sh0000_0100;
    step_pulse();
    check("sat_step_max", o_step, 64'h7FFF_FFFF);
    check("sat_flag", o_sat, 1);
    tick();
    i_err = -32'sd16;
    step_pulse();
    check("sat_recover", o_step, 64'h7FFF_FFEF);
    tick();

    // Ramp wrap
    clear_loop();
    i_fb_on = 1'b0; i_const_step = 32'shFFFF_FFF0;
    step_pulse(); ramp_pulse();
    check("wrap_pre", o_ramp, 64'hFFFF_FFF0);
    i_const_step = 32'sh0000_0020;
    step_pulse(); ramp_pulse();
    check("wrap_ramp", o_ramp, 64'h0000_0010);
    i_mod_l = 16'sh1234; i_polarity = 1'b0;
    tick();
    check("wrap_dac", o_dac, 64'h1234);

    // Open loop, step/ramp sync pairs
    clear_loop();
    i_const_step = 32'sh0100_0000; i_mod_l = 16'sh0010; i_mod_h = -16'sd16;
    repeat (4) begin
      step_pulse(); ramp_pulse();
    end
    check("ol_ramp", o_ramp, 64'h0400_0000);
    tick();
    check("ol_dac_l", o_dac, 64'h0410);
    i_polarity = 1'b1;
    tick();
    check("ol_dac_h", o_dac, 64'h03F0);

    // Busy sync, then abort during ACCUM
    clear_loop();
    i_fb_on = 1'b1; i_gain1_sel = 5'd0; i_gain2_sel = 5'd0; i_err = 32'sd7;
    i_step_sync = 1'b1; tick(); tick();
    i_step_sync = 1'b0; tick();
    check("busy_step", o_step, 7);
    check("busy_miss", o_sync_miss, 1);
    tick();
    i_err = 32'sd5;
    i_step_sync = 1'b1; tick();
    i_step_sync = 1'b0; tick();
    i_status = 1'b0; tick();
    check("abort_step", o_step, 0);
    check("abort_ramp", o_ramp, 0);
    check("abort_miss", o_sync_miss, 0);
    i_status = 1'b1; tick(); tick();
    check("abort_hold", o_step, 0);

    // Randomized traffic
    repeat (500) begin
      i_status     = ($urandom_range(0, 31) != 0);
      i_step_sync  = ($urandom_range(0, 3) == 0);
      i_ramp_sync  = ($urandom_range(0, 2) == 0);
      i_fb_on      = ($urandom_range(0, 3) != 0);
      i_polarity   = 1'($urandom);
      i_err        = $urandom;
      i_gain1_sel  = 5'($urandom);
      i_gain2_sel  = 5'($urandom);
      i_const_step = $urandom;
      i_mod_h      = 16'($urandom);
      i_mod_l      = 16'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
